// File: rtl/dcmac_reset_pkg.sv
// Shared types and constants for the DCMAC port reset sequencer.
package dcmac_reset_pkg;

  localparam int CNT_W   = 20;
  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_ASSERT_ALL   = 3'd0,
    ST_WAIT_GT      = 3'd1,
    ST_CORE_SETTLE  = 3'd2,
    ST_WAIT_RX_LOCK = 3'd3,
    ST_RUN          = 3'd4,
    ST_FAULT        = 3'd5
  } seq_state_e;

  // Registered output bundle, decoded from the state being entered.
  typedef struct packed {
    logic gt_reset;
    logic core_resetn;
    logic tx_resetn;
    logic rx_resetn;
    logic seq_busy;
    logic seq_fault;
  } seq_outs_t;

  localparam seq_outs_t OUTS_RESET = '{
    gt_reset:    1'b1,
    core_resetn: 1'b0,
    tx_resetn:   1'b0,
    rx_resetn:   1'b0,
    seq_busy:    1'b1,
    seq_fault:   1'b0
  };

  // Reset pattern driven while sitting in a given state.
  function automatic seq_outs_t decode_outputs(input seq_state_e st);
    seq_outs_t o;
    o = OUTS_RESET;
    case (st)
      ST_WAIT_GT: begin
        o.gt_reset = 1'b0;
      end
      ST_CORE_SETTLE: begin
        o.gt_reset    = 1'b0;
        o.core_resetn = 1'b1;
      end
      ST_WAIT_RX_LOCK: begin
        o.gt_reset    = 1'b0;
        o.core_resetn = 1'b1;
        o.tx_resetn   = 1'b1;
      end
      ST_RUN: begin
        o.gt_reset    = 1'b0;
        o.core_resetn = 1'b1;
        o.tx_resetn   = 1'b1;
        o.rx_resetn   = 1'b1;
        o.seq_busy    = 1'b0;
      end
      ST_FAULT: begin
        o.seq_busy  = 1'b0;
        o.seq_fault = 1'b1;
      end
      default: o = OUTS_RESET;
    endcase
    return o;
  endfunction

  // Saturating increment for the retry counter.
  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/dcmac_sync_bit.sv
// Two-flop synchronizer for a level signal from another clock domain.
module dcmac_sync_bit (
  input  logic clk,
  input  logic resetn_async_inv,
  input  logic d_async,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;

  // Capture the asynchronous level and let the first stage settle for a cycle.
  // NOTE: sequential state uses non-blocking assignments so both stages sample the pre-edge values.
  always_ff @(posedge clk or negedge resetn_async_inv) begin
    if (!resetn_async_inv) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_async;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dcmac_reset_sequencer.sv
// Ordered reset controller for one DCMAC port: GT, core, TX, then RX,
// with timeout/retry on the GT and RX-lock handshakes.
module dcmac_reset_sequencer
  import dcmac_reset_pkg::*;
#(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       resetn_async_inv,
  input  logic       sw_reset_req,
  input  logic       gt_reset_done,
  input  logic       gt_rx_lock,
  output logic       gt_reset,
  output logic       core_resetn,
  output logic       tx_resetn,
  output logic       rx_resetn,
  output logic       seq_busy,
  output logic       seq_fault,
  output logic [2:0] seq_state,
  output logic [3:0] retry_cnt
);

  // The counter holds (cycles already spent in the state - 1) at the edge that
  // completes the Nth cycle, so each limit compares against N-1.
  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  seq_outs_t          outs_q, outs_d;

  logic gt_done_s;
  logic rx_lock_s;
  logic hold_done;
  logic timed_out;
  logic [RETRY_W-1:0] retry_inc;

  dcmac_sync_bit u_sync_gt_done (
    .clk              (clk),
    .resetn_async_inv (resetn_async_inv),
    .d_async          (gt_reset_done),
    .q                (gt_done_s)
  );

  dcmac_sync_bit u_sync_rx_lock (
    .clk              (clk),
    .resetn_async_inv (resetn_async_inv),
    .d_async          (gt_rx_lock),
    .q                (rx_lock_s)
  );

  assign hold_done = (cnt_q == HOLD_LAST);
  assign timed_out = (cnt_q == TIMEOUT_LAST);
  assign retry_inc = sat_inc(retry_q);

  // Next state, retry bookkeeping, shared counter and output decode.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can infer a latch.
    state_d = state_q;
    retry_d = retry_q;

    if (sw_reset_req) begin
      state_d = ST_ASSERT_ALL;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT_ALL: begin
          if (hold_done) state_d = ST_WAIT_GT;
        end
        ST_WAIT_GT: begin
          if (gt_done_s) begin
            state_d = ST_CORE_SETTLE;
          end else if (timed_out) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_ASSERT_ALL;
          end
        end
        ST_CORE_SETTLE: begin
          if (hold_done) state_d = ST_WAIT_RX_LOCK;
        end
        ST_WAIT_RX_LOCK: begin
          if (rx_lock_s) begin
            state_d = ST_RUN;
            retry_d = '0;
          end else if (timed_out) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_ASSERT_ALL;
          end
        end
        ST_RUN: begin
          if (!rx_lock_s) state_d = ST_WAIT_RX_LOCK;
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_ASSERT_ALL;
        end
      endcase
    end

    // Counter restarts on every state entry and on a software request; it
    // idles at zero in the untimed states.
    if (sw_reset_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_FAULT)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    outs_d = decode_outputs(state_d);
  end

  // State, counter, retry count and decoded outputs.
  always_ff @(posedge clk or negedge resetn_async_inv) begin
    if (!resetn_async_inv) begin
      state_q <= ST_ASSERT_ALL;
      cnt_q   <= '0;
      retry_q <= '0;
      outs_q  <= OUTS_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      outs_q  <= outs_d;
    end
  end

  assign gt_reset    = outs_q.gt_reset;
  assign core_resetn = outs_q.core_resetn;
  assign tx_resetn   = outs_q.tx_resetn;
  assign rx_resetn   = outs_q.rx_resetn;
  assign seq_busy    = outs_q.seq_busy;
  assign seq_fault   = outs_q.seq_fault;
  assign seq_state   = state_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_dcmac_reset_sequencer.sv
// Directed bench for dcmac_reset_sequencer (HOLD=16, TIMEOUT=64, MAX_RETRY=3).
// Edge numbers count rising edges since the last reset release; inputs change
// 1 time unit after an edge and outputs are sampled at that same point.
module tb_dcmac_reset_sequencer;

  localparam int H = 16;
  localparam int T = 64;

  localparam int S_ASSERT = 0;
  localparam int S_WGT    = 1;
  localparam int S_CORE   = 2;
  localparam int S_WRX    = 3;
  localparam int S_RUN    = 4;
  localparam int S_FAULT  = 5;

  logic       clk;
  logic       resetn_async_inv;
  logic       sw_reset_req;
  logic       gt_reset_done;
  logic       gt_rx_lock;
  logic       gt_reset;
  logic       core_resetn;
  logic       tx_resetn;
  logic       rx_resetn;
  logic       seq_busy;
  logic       seq_fault;
  logic [2:0] seq_state;
  logic [3:0] retry_cnt;

  logic [12:0] outs;
  logic [12:0] expv;
  int          cyc;
  int          tests_run;
  int          tests_failed;

  dcmac_reset_sequencer #(
    .HOLD_CYCLES    (H),
    .TIMEOUT_CYCLES (T),
    .MAX_RETRY      (3)
  ) dut (
    .clk              (clk),
    .resetn_async_inv (resetn_async_inv),
    .sw_reset_req     (sw_reset_req),
    .gt_reset_done    (gt_reset_done),
    .gt_rx_lock       (gt_rx_lock),
    .gt_reset         (gt_reset),
    .core_resetn      (core_resetn),
    .tx_resetn        (tx_resetn),
    .rx_resetn        (rx_resetn),
    .seq_busy         (seq_busy),
    .seq_fault        (seq_fault),
    .seq_state        (seq_state),
    .retry_cnt        (retry_cnt)
  );

  assign outs = {gt_reset, core_resetn, tx_resetn, rx_resetn, seq_busy, seq_fault,
                 seq_state, retry_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {gt_reset, core_resetn, tx_resetn, rx_resetn, busy, fault, state, retry}.
  function automatic logic [12:0] exp_vec(input int st, input int rc);
    logic [5:0] o;
    case (st)
      S_ASSERT: o = 6'b100010;
      S_WGT:    o = 6'b000010;
      S_CORE:   o = 6'b010010;
      S_WRX:    o = 6'b011010;
      S_RUN:    o = 6'b011100;
      S_FAULT:  o = 6'b100001;
      default:  o = 6'bxxxxxx;
    endcase
    return {o, 3'(st), 4'(rc)};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto_cycle(input int c);
    step(c - cyc);
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn_async_inv = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    resetn_async_inv = 1'b1;
    sw_reset_req     = 1'b0;
    gt_reset_done    = 1'b0;
    gt_rx_lock       = 1'b0;
    #2;
    resetn_async_inv = 1'b0;
    #1;
    expv = exp_vec(S_ASSERT, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL reset_immediate: got %b expected %b", outs, expv); end
    repeat (3) @(posedge clk);
    #1;
    expv = exp_vec(S_ASSERT, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL reset_held: got %b expected %b", outs, expv); end
    release_reset();
  endtask

  task automatic test_power_up();
    goto_cycle(15);
    expv = exp_vec(S_ASSERT, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL pu_hold_15: got %b expected %b", outs, expv); end
    goto_cycle(16);
    expv = exp_vec(S_WGT, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL pu_gt_fall_16: got %b expected %b", outs, expv); end
    goto_cycle(40);
    gt_reset_done = 1'b1;
    goto_cycle(42);
    expv = exp_vec(S_WGT, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL pu_core_42: got %b expected %b", outs, expv); end
    goto_cycle(43);
    expv = exp_vec(S_CORE, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL pu_core_43: got %b expected %b", outs, expv); end
    goto_cycle(58);
    expv = exp_vec(S_CORE, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL pu_tx_58: got %b expected %b", outs, expv); end
    goto_cycle(59);
    expv = exp_vec(S_WRX, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL pu_tx_59: got %b expected %b", outs, expv); end
    goto_cycle(100);
    gt_rx_lock = 1'b1;
    goto_cycle(102);
    expv = exp_vec(S_WRX, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL pu_rx_102: got %b expected %b", outs, expv); end
    goto_cycle(103);
    expv = exp_vec(S_RUN, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL pu_run_103: got %b expected %b", outs, expv); end
  endtask

  task automatic test_rx_lock_loss();
    goto_cycle(110);
    gt_rx_lock = 1'b0;
    goto_cycle(112);
    expv = exp_vec(S_RUN, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL lol_fall_112: got %b expected %b", outs, expv); end
    goto_cycle(113);
    expv = exp_vec(S_WRX, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL lol_fall_113: got %b expected %b", outs, expv); end
    goto_cycle(120);
    gt_rx_lock = 1'b1;
    goto_cycle(122);
    expv = exp_vec(S_WRX, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL lol_rise_122: got %b expected %b", outs, expv); end
    goto_cycle(123);
    expv = exp_vec(S_RUN, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL lol_rise_123: got %b expected %b", outs, expv); end
  endtask

  // WAIT_RX_LOCK is entered at edge 133 and would time out at edge 197.
  task automatic test_sw_vs_timeout();
    goto_cycle(130);
    gt_rx_lock = 1'b0;
    goto_cycle(196);
    expv = exp_vec(S_WRX, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL swto_pre_196: got %b expected %b", outs, expv); end
    sw_reset_req = 1'b1;
    goto_cycle(197);
    sw_reset_req = 1'b0;
    gt_rx_lock   = 1'b1;
    expv = exp_vec(S_ASSERT, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL swto_197: got %b expected %b", outs, expv); end
    goto_cycle(213);
    expv = exp_vec(S_WGT, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL swto_wgt_213: got %b expected %b", outs, expv); end
    goto_cycle(214);
    expv = exp_vec(S_CORE, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL swto_core_214: got %b expected %b", outs, expv); end
    goto_cycle(231);
    expv = exp_vec(S_RUN, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL swto_run_231: got %b expected %b", outs, expv); end
  endtask

  // Request at 241; WAIT_GT windows start 257/337/417 and time out at 321/401/481.
  task automatic test_fault_retry();
    goto_cycle(240);
    gt_reset_done = 1'b0;
    gt_rx_lock    = 1'b0;
    sw_reset_req  = 1'b1;
    goto_cycle(241);
    sw_reset_req = 1'b0;
    expv = exp_vec(S_ASSERT, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL flt_start_241: got %b expected %b", outs, expv); end
    goto_cycle(320);
    expv = exp_vec(S_WGT, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL flt_pre_to1_320: got %b expected %b", outs, expv); end
    goto_cycle(321);
    expv = exp_vec(S_ASSERT, 1); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL flt_to1_321: got %b expected %b", outs, expv); end
    goto_cycle(401);
    expv = exp_vec(S_ASSERT, 2); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL flt_to2_401: got %b expected %b", outs, expv); end
    goto_cycle(480);
    expv = exp_vec(S_WGT, 2); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL flt_pre_to3_480: got %b expected %b", outs, expv); end
    goto_cycle(481);
    expv = exp_vec(S_FAULT, 3); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL flt_fault_481: got %b expected %b", outs, expv); end
    goto_cycle(505);
    expv = exp_vec(S_FAULT, 3); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL flt_frozen_505: got %b expected %b", outs, expv); end
    sw_reset_req = 1'b1;
    goto_cycle(506);
    sw_reset_req = 1'b0;
    expv = exp_vec(S_ASSERT, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL flt_clear_506: got %b expected %b", outs, expv); end
    goto_cycle(530);
    gt_reset_done = 1'b1;
    goto_cycle(533);
    gt_rx_lock = 1'b1;
    expv = exp_vec(S_CORE, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL flt_core_533: got %b expected %b", outs, expv); end
    goto_cycle(550);
    expv = exp_vec(S_RUN, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL flt_run_550: got %b expected %b", outs, expv); end
  endtask

  // Request at 561; first WAIT_GT (577) times out at 641, second (657) would at 721,
  // where the synchronized done arrives in the same cycle.
  task automatic test_handshake_vs_timeout();
    goto_cycle(560);
    gt_reset_done = 1'b0;
    sw_reset_req  = 1'b1;
    goto_cycle(561);
    sw_reset_req = 1'b0;
    goto_cycle(641);
    expv = exp_vec(S_ASSERT, 1); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL hvt_to1_641: got %b expected %b", outs, expv); end
    goto_cycle(718);
    gt_reset_done = 1'b1;
    goto_cycle(720);
    expv = exp_vec(S_WGT, 1); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL hvt_pre_720: got %b expected %b", outs, expv); end
    goto_cycle(721);
    expv = exp_vec(S_CORE, 1); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL hvt_advance_721: got %b expected %b", outs, expv); end
  endtask

  task automatic test_async_reset();
    goto_cycle(726);
    expv = exp_vec(S_CORE, 1); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL ar_pre_726: got %b expected %b", outs, expv); end
    #1;
    resetn_async_inv = 1'b0;
    #1;
    expv = exp_vec(S_ASSERT, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL ar_immediate: got %b expected %b", outs, expv); end
    @(posedge clk);
    release_reset();
    goto_cycle(15);
    expv = exp_vec(S_ASSERT, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL ar_hold_15: got %b expected %b", outs, expv); end
    goto_cycle(16);
    expv = exp_vec(S_WGT, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL ar_gt_16: got %b expected %b", outs, expv); end
    goto_cycle(17);
    expv = exp_vec(S_CORE, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL ar_core_17: got %b expected %b", outs, expv); end
    goto_cycle(32);
    expv = exp_vec(S_CORE, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL ar_tx_32: got %b expected %b", outs, expv); end
    goto_cycle(33);
    expv = exp_vec(S_WRX, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL ar_tx_33: got %b expected %b", outs, expv); end
    goto_cycle(34);
    expv = exp_vec(S_RUN, 0); tests_run++;
    if (outs !== expv) begin tests_failed++; $display("FAIL ar_run_34: got %b expected %b", outs, expv); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    test_reset();
    test_power_up();
    test_rx_lock_loss();
    test_sw_vs_timeout();
    test_fault_retry();
    test_handshake_vs_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dcmac_reset_sequencer.md
# dcmac_reset_sequencer

Ordered reset controller for one DCMAC port. It takes the board-level synchronized reset and brings the GT, the DCMAC core, the TX datapath and the RX datapath out of reset in a fixed order. Each step is gated on hold times and on status handshakes from the GT and the core. Stalls are handled by timeout and retry, and loss of RX lock is recovered by resetting the RX side only.

## Interface
Parameters:
- HOLD_CYCLES, 16, minimum cycles any reset stays asserted, and settle time after core release; range 2..65535
- TIMEOUT_CYCLES, 65535, maximum cycles spent in any wait state before a retry; range 16..2^20-1
- MAX_RETRY, 3, consecutive timeouts tolerated before FAULT; range 1..15

Ports:
- clk  in  1  sequencer clock; all outputs registered on its rising edge
- resetn_async_inv  in  1  reset, asynchronous, active-low
- sw_reset_req  in  1  clk-synchronous single-cycle request to restart the sequence
- gt_reset_done  in  1  GT reset complete, asynchronous, level
- gt_rx_lock  in  1  GT RX CDR/alignment lock, asynchronous, level
- gt_reset  out  1  GT reset, active-high
- core_resetn  out  1  DCMAC core reset, active-low
- tx_resetn  out  1  TX datapath reset, active-low
- rx_resetn  out  1  RX datapath reset, active-low
- seq_busy  out  1  high in every state except RUN and FAULT
- seq_fault  out  1  high only in FAULT
- seq_state  out  3  current state encoding
- retry_cnt  out  4  consecutive timeouts since last success or sw request

## Operation
- gt_reset_done and gt_rx_lock pass through 2-flop synchronizers. All references below are to the synchronized versions.
- States and encodings: ASSERT_ALL 0, WAIT_GT 1, CORE_SETTLE 2, WAIT_RX_LOCK 3, RUN 4, FAULT 5.
- ASSERT_ALL: all four resets asserted. Cycle counter runs; after HOLD_CYCLES go to WAIT_GT with gt_reset deasserted.
- WAIT_GT: gt_reset low; others asserted. When gt_reset_done=1, set core_resetn=1 and go to CORE_SETTLE.
- CORE_SETTLE: after HOLD_CYCLES, set tx_resetn=1 and go to WAIT_RX_LOCK.
- WAIT_RX_LOCK: when gt_rx_lock=1, set rx_resetn=1, clear retry_cnt and go to RUN.
- RUN: all resets deasserted. If gt_rx_lock=0, set rx_resetn=0 and go to WAIT_RX_LOCK. GT, core and TX stay out of reset.
- Timeout: WAIT_GT and WAIT_RX_LOCK each count cycles from state entry. On reaching TIMEOUT_CYCLES, retry_cnt increments.
  - If the new value equals MAX_RETRY, go to FAULT.
  - Otherwise go to ASSERT_ALL.
- FAULT: all resets asserted, retry_cnt frozen. Exit only via sw_reset_req.
- sw_reset_req=1 in any state: go to ASSERT_ALL, clear retry_cnt and restart the counter. This has priority over a timeout, a handshake arrival and loss of lock in the same cycle.
- A handshake that arrives in the same cycle as a timeout wins; the state advances and there is no retry.
- retry_cnt saturates at 15.

## Timing
- While resetn_async_inv=0: state ASSERT_ALL, gt_reset=1, core_resetn=0, tx_resetn=0, rx_resetn=0, seq_busy=1, seq_fault=0, retry_cnt=0, counter=0.
- Cycle 1 is the first rising edge with resetn_async_inv=1. gt_reset falls on edge HOLD_CYCLES.
- core_resetn rises 1 edge after synchronized gt_reset_done is sampled high, which is 3 edges after the raw input rises.
- tx_resetn rises HOLD_CYCLES edges after core_resetn.
- rx_resetn rises 3 edges after raw gt_rx_lock rises while in WAIT_RX_LOCK.
- rx_resetn falls 3 edges after raw gt_rx_lock falls while in RUN.
- Assertion of resetn_async_inv at any point returns all outputs to reset values immediately (asynchronous).
- Counter: 20 bits, cleared on every state entry. It compares against the parameter in use for the current state.

## Structure
- Package dcmac_reset_pkg holds:
  - the state enum with the encodings above
  - the counter width constant (20)
  - the retry width constant (4)
- Sub-module dcmac_sync_bit: 2-flop ASYNC_REG synchronizer, reset low by resetn_async_inv. Instantiated twice.
- Single FSM with one shared cycle counter. Outputs are decoded from the next state and registered.

## Test plan
- Power-up, H=16, gt_reset_done rises at cycle 40, gt_rx_lock rises at cycle 100 -> gt_reset falls at cycle 16; core_resetn rises at cycle 43; tx_resetn rises at cycle 59; rx_resetn rises at cycle 103; seq_state=4, seq_busy=0.
- TIMEOUT_CYCLES=64, MAX_RETRY=3, gt_reset_done held 0 -> three WAIT_GT timeouts, each restarting ASSERT_ALL -> seq_fault=1, retry_cnt=3, all resets asserted. sw_reset_req then clears retry_cnt and the sequence completes when done rises.
- In RUN, drop gt_rx_lock for 10 cycles -> rx_resetn low 3 edges after the fall; gt_reset, core_resetn and tx_resetn unchanged; rx_resetn returns high 3 edges after lock returns.
- sw_reset_req in the same cycle as a WAIT_RX_LOCK timeout -> ASSERT_ALL with retry_cnt=0, not incremented.
- resetn_async_inv pulsed low mid CORE_SETTLE -> outputs at reset values within the same cycle; full sequence replays with correct hold counts.
- Handshake and timeout in the same cycle (gt_reset_done rises exactly at TIMEOUT_CYCLES) -> advance to CORE_SETTLE, retry_cnt unchanged.
